round_robin_arbiter_n: RTL and testbench

ROUND_ROBIN_ARBITER_N -- requirements
Module: round_robin_arbiter_n

---
 rtl/arbiter_pkg.sv | 14 +
 rtl/rr_priority_pick.sv | 34 +++
 rtl/round_robin_arbiter_n.sv | 91 +++++++++
 tb/tb_round_robin_arbiter_n.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared arbiter definitions: legal parameter ranges and index-width helper.
package arbiter_pkg;

  localparam int N_MIN         = 2;
  localparam int N_MAX         = 32;
  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 255;

  // Width needed to hold indices 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority search: first set request at or after start, wrapping modulo N.
module rr_priority_pick
  import arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int            pos;
    logic [IW-1:0] p;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    p     = '0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) + k) % N;
      p   = IW'(pos);
      if (!found && req[p]) begin
        found   = 1'b1;
        pick[p] = 1'b1;
        idx     = p;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-way round-robin arbiter, zero-latency grant, burst-limited ownership.
// The current owner keeps the grant for up to MAX_BURST cycles while others wait.
module round_robin_arbiter_n
  import arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              requests,
  output logic [N-1:0]              grants,
  output logic                      grant_valid,
  output logic [idx_width(N)-1:0]   grant_idx
);

  localparam int IW = idx_width(N);
  localparam int BW = idx_width(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("round_robin_arbiter_n: N out of range");
  end
  if (MAX_BURST < MAX_BURST_MIN || MAX_BURST > MAX_BURST_MAX) begin : g_bad_burst
    $error("round_robin_arbiter_n: MAX_BURST out of range");
  end

  logic [IW-1:0] owner;
  logic          owner_valid;
  logic [BW-1:0] burst_cnt;

  logic [N-1:0]  owner_mask;
  logic          others_req;
  logic          hold;
  logic [IW-1:0] scan_start;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          pick_found;

  assign owner_mask = N'(1) << owner;
  assign others_req = |(requests & ~owner_mask);
  assign hold       = owner_valid && requests[owner] &&
                      ((burst_cnt < BURST_LAST) || !others_req);

  // Owner is scanned last: start one past it, wrapping from N-1 to 0.
  always_comb begin
    scan_start = '0;
    if (owner_valid && owner != LAST_IDX) begin
      scan_start = owner + IW'(1);
    end
  end

  rr_priority_pick #(.N(N), .IW(IW)) u_pick (
    .req   (requests),
    .start (scan_start),
    .pick  (pick),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    grants      = pick;
    grant_idx   = pick_idx;
    grant_valid = pick_found;
    if (hold) begin
      grants      = owner_mask;
      grant_idx   = owner;
      grant_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= '0;
      owner_valid <= 1'b0;
      burst_cnt   <= '0;
    end else if (grant_valid) begin
      owner       <= grant_idx;
      owner_valid <= 1'b1;
      if (owner_valid && grant_idx == owner) begin
        burst_cnt <= (burst_cnt == BURST_LAST) ? burst_cnt : burst_cnt + BW'(1);
      end else begin
        burst_cnt <= '0;
      end
    end else begin
      burst_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Directed-vector bench for round_robin_arbiter_n across several N/MAX_BURST configurations.
module tb_round_robin_arbiter_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // d0: N=2 MB=1, d1: N=4 MB=1, d2: N=4 MB=3, d3: N=4 MB=2
  logic [1:0] req0 = '0, gnt0;
  logic [3:0] req1 = '0, gnt1;
  logic [3:0] req2 = '0, gnt2;
  logic [3:0] req3 = '0, gnt3;
  logic       vld0, vld1, vld2, vld3;
  logic       idx0;
  logic [1:0] idx1, idx2, idx3;

  round_robin_arbiter_n #(.N(2), .MAX_BURST(1)) u_d0 (
    .clk(clk), .rst(rst), .requests(req0), .grants(gnt0), .grant_valid(vld0), .grant_idx(idx0));
  round_robin_arbiter_n #(.N(4), .MAX_BURST(1)) u_d1 (
    .clk(clk), .rst(rst), .requests(req1), .grants(gnt1), .grant_valid(vld1), .grant_idx(idx1));
  round_robin_arbiter_n #(.N(4), .MAX_BURST(3)) u_d2 (
    .clk(clk), .rst(rst), .requests(req2), .grants(gnt2), .grant_valid(vld2), .grant_idx(idx2));
  round_robin_arbiter_n #(.N(4), .MAX_BURST(2)) u_d3 (
    .clk(clk), .rst(rst), .requests(req3), .grants(gnt3), .grant_valid(vld3), .grant_idx(idx3));

  typedef struct {
    int         dut;
    bit         do_rst;
    logic [3:0] req;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [2:0] exp_vi(input logic [3:0] oh);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < 4; i++) if (oh[i]) r = {1'b1, 2'(i)};
    return r;
  endfunction

  task automatic add(input int d, input bit r, input logic [3:0] rq, input logic [3:0] ex);
    vec_t v;
    v.dut = d; v.do_rst = r; v.req = rq; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic drive(input int d, input logic [3:0] rq);
    req0 = '0; req1 = '0; req2 = '0; req3 = '0;
    case (d)
      0: req0 = rq[1:0];
      1: req1 = rq;
      2: req2 = rq;
      default: req3 = rq;
    endcase
  endtask

  task automatic sample(input int d, output logic [3:0] g, output logic [2:0] vi);
    case (d)
      0: begin g = {2'b00, gnt0}; vi = {vld0, 1'b0, idx0}; end
      1: begin g = gnt1; vi = {vld1, idx1}; end
      2: begin g = gnt2; vi = {vld2, idx2}; end
      default: begin g = gnt3; vi = {vld3, idx3}; end
    endcase
  endtask

  task automatic check_now(input string name, input int d, input logic [3:0] ex);
    logic [3:0] g;
    logic [2:0] vi;
    sample(d, g, vi);
    check({name, ".grants"}, g, ex);
    check({name, ".vld_idx"}, {1'b0, vi}, {1'b0, exp_vi(ex)});
  endtask

  // Entered just after a falling edge; leaves just after the next one.
  task automatic apply(input string name, input int d, input logic [3:0] rq, input logic [3:0] ex);
    drive(d, rq);
    #1;
    check_now(name, d, ex);
    @(negedge clk);
  endtask

  task automatic do_reset(input int d);
    drive(d, 4'b0000);
    rst = 1'b1;
    #1;
    check_now($sformatf("reset_d%0d", d), d, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // N=2 basic rotation
    add(0, 1, 4'b01, 4'b01); add(0, 0, 4'b00, 4'b00); add(0, 0, 4'b10, 4'b10);
    add(0, 0, 4'b11, 4'b01); add(0, 0, 4'b11, 4'b10); add(0, 0, 4'b00, 4'b00);
    add(0, 0, 4'b11, 4'b01); add(0, 0, 4'b00, 4'b00); add(0, 0, 4'b11, 4'b10);
    add(0, 0, 4'b11, 4'b01);
    // N=4 MB=1 all requesting
    for (int i = 0; i < 8; i++) add(1, i == 0, 4'b1111, 4'b0001 << (i % 4));
    // N=4 MB=3 all requesting
    for (int i = 0; i < 9; i++) add(2, i == 0, 4'b1111, 4'b0001 << (i / 3));
    // N=4 MB=2 sole requester then contention
    for (int i = 0; i < 5; i++) add(3, i == 0, 4'b0001, 4'b0001);
    add(3, 0, 4'b0011, 4'b0010); add(3, 0, 4'b0011, 4'b0010); add(3, 0, 4'b0011, 4'b0001);
    // Wrap from owner 3
    add(1, 1, 4'b1000, 4'b1000); add(1, 0, 4'b1001, 4'b0001); add(1, 0, 4'b1001, 4'b1000);
    // Withdrawal mid-burst restarts the burst count
    add(2, 1, 4'b0011, 4'b0001); add(2, 0, 4'b0011, 4'b0001); add(2, 0, 4'b0010, 4'b0010);
    add(2, 0, 4'b0011, 4'b0010); add(2, 0, 4'b0011, 4'b0010); add(2, 0, 4'b0011, 4'b0001);
    // Idle cycle ends a burst
    add(2, 1, 4'b0011, 4'b0001); add(2, 0, 4'b0011, 4'b0001); add(2, 0, 4'b0000, 4'b0000);
    add(2, 0, 4'b0011, 4'b0001); add(2, 0, 4'b0011, 4'b0001); add(2, 0, 4'b0011, 4'b0010);

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset(vecs[i].dut);
      apply($sformatf("vec%0d_d%0d", i, vecs[i].dut), vecs[i].dut, vecs[i].req, vecs[i].exp);
    end

    // Asynchronous reset mid-burst on N=4 MB=3
    do_reset(2);
    apply("ar_start", 2, 4'b0100, 4'b0100);
    apply("ar_hold", 2, 4'b0110, 4'b0100);
    drive(2, 4'b0110);
    #2;
    check_now("ar_pre_rst", 2, 4'b0100);
    rst = 1'b1;
    #1;
    check_now("ar_in_rst", 2, 4'b0010);
    @(posedge clk);
    #1;
    check_now("ar_rst_edge", 2, 4'b0010);
    @(negedge clk);
    rst = 1'b0;
    apply("ar_post0", 2, 4'b0110, 4'b0010);
    apply("ar_post1", 2, 4'b0110, 4'b0010);
    apply("ar_post2", 2, 4'b0110, 4'b0010);
    apply("ar_post3", 2, 4'b0110, 4'b0100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
